hwjsoc_inst_fetch_b: RTL and testbench

Instruction prefetch unit sitting directly downstream of the 8192×32 single-port instruction memory B (13-bit word address, 1-cycle read latency). It issues sequential word reads, buffers returned words in a small FIFO and presents them to the core as a valid/ready instruction stream tagged with the word PC. It supports start, halt and redirect with flush of stale data.

---
 rtl/hwjsoc_inst_fetch_b_if.sv | 32 +++
 rtl/hwjsoc_inst_fetch_b.sv | 120 ++++++++++++
 tb/tb_hwjsoc_inst_fetch_b.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/hwjsoc_inst_fetch_b_if.sv
// Fetch-unit bus bundle: read port toward instruction memory B and the
// valid/ready instruction stream toward the core.
interface hwjsoc_inst_fetch_b_if #(
    parameter int ADDR_W = 13
);
    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_write;
    logic [3:0]        mem_byteenable;
    logic              mem_clken;
    logic [31:0]       mem_readdata;

    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr_data;
    logic [ADDR_W-1:0] instr_pc;

    // master = fetch unit, slave = memory plus consuming core
    modport master (
        output mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
        input  mem_readdata,
        output instr_valid, instr_data, instr_pc,
        input  instr_ready
    );

    modport slave (
        input  mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
        output mem_readdata,
        input  instr_valid, instr_data, instr_pc,
        output instr_ready
    );
endinterface

// File: rtl/hwjsoc_inst_fetch_b.sv
// Sequential instruction prefetcher for memory B: issues word reads, buffers
// returned words in a small FIFO and streams {data, pc} to the core.
module hwjsoc_inst_fetch_b #(
    parameter int          DEPTH    = 4,
    parameter int          ADDR_W   = 13,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_pc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              busy,
    hwjsoc_inst_fetch_b_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] fetch_pc_q;
    logic [ADDR_W-1:0] pend_pc_q;
    logic              pending_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic [31:0]       data_q [DEPTH];
    logic [ADDR_W-1:0] pc_q   [DEPTH];

    logic              flush;
    logic              issue;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] target_pc;

    assign flush     = redirect | start;
    assign target_pc = redirect ? redirect_pc : start_pc;
    // Credit counts the in-flight read so the FIFO can never overflow.
    assign issue     = (state_q == RUN) &&
                       ((count_q + CNT_W'(pending_q)) < CNT_W'(DEPTH));
    assign push      = pending_q & ~flush;
    assign pop       = bus.instr_valid & bus.instr_ready;

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_ADDR;
            pend_pc_q  <= RESET_ADDR;
            pending_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            count_q <= count_d;
            if (flush) begin
                // A read issued this cycle belongs to the old stream; drop it.
                state_q    <= RUN;
                fetch_pc_q <= target_pc;
                pending_q  <= 1'b0;
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
            end else begin
                if (halt) begin
                    state_q <= IDLE;
                end
                pending_q <= issue;
                if (issue) begin
                    pend_pc_q  <= fetch_pc_q;
                    fetch_pc_q <= fetch_pc_q + ADDR_W'(1);
                end
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else if (push) begin
            data_q[wr_ptr_q] <= bus.mem_readdata;
            pc_q[wr_ptr_q]   <= pend_pc_q;
        end
    end

    assign bus.mem_address    = fetch_pc_q;
    assign bus.mem_chipselect = issue;
    assign bus.mem_write      = 1'b0;
    assign bus.mem_byteenable = 4'hF;
    assign bus.mem_clken      = 1'b1;

    assign bus.instr_valid = (count_q != '0);
    assign bus.instr_data  = data_q[rd_ptr_q];
    assign bus.instr_pc    = pc_q[rd_ptr_q];

    assign busy = (state_q == RUN) | pending_q | (count_q != '0);
endmodule

// File: tb/tb_hwjsoc_inst_fetch_b.sv
// Directed bench for hwjsoc_inst_fetch_b with a 1-cycle-latency memory model
// whose word n reads as 0xA000_0000 + n.
module tb_hwjsoc_inst_fetch_b;
    localparam int AW = 13;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          redirect = 1'b0;
    logic          halt = 1'b0;
    logic          instr_ready = 1'b0;
    logic [AW-1:0] start_pc = '0;
    logic [AW-1:0] redirect_pc = '0;
    logic          busy;
    logic [31:0]   mem_rdata_q = '0;

    int vectors = 0;
    int miscompares = 0;

    hwjsoc_inst_fetch_b_if #(.ADDR_W(AW)) bus ();

    hwjsoc_inst_fetch_b #(
        .DEPTH    (4),
        .ADDR_W   (AW),
        .RESET_PC (0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .start_pc    (start_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .busy        (busy),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_chipselect && bus.mem_clken)
            mem_rdata_q <= 32'hA000_0000 + 32'(bus.mem_address);
    end
    assign bus.mem_readdata = mem_rdata_q;
    assign bus.instr_ready  = instr_ready;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // FIFO occupancy beyond DEPTH would mean a lost word
    always @(negedge clk) begin
        if (!reset && dut.count_q > 3'd4)
            check("fifo_overflow", 32'(dut.count_q), 32'd4);
    end

    function automatic logic [31:0] word(input logic [AW-1:0] a);
        return 32'hA000_0000 + 32'(a);
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_start(input logic [AW-1:0] pc);
        start    = 1'b1;
        start_pc = pc;
        tick();
        start    = 1'b0;
    endtask

    task automatic collect(input int n, input logic [AW-1:0] first, input int budget);
        logic [AW-1:0] exp_pc;
        int            got;
        exp_pc = first;
        got = 0;
        instr_ready = 1'b1;
        for (int c = 0; c < budget && got < n; c++) begin
            if (bus.instr_valid) begin
                $display("pop pc=%h data=%h", bus.instr_pc, bus.instr_data);
                check("stream_pc", 32'(bus.instr_pc), 32'(exp_pc));
                check("stream_data", bus.instr_data, word(exp_pc));
                exp_pc = exp_pc + AW'(1);
                got++;
            end
            tick();
        end
        check("stream_count", 32'(got), 32'(n));
    endtask

    task automatic drain(input logic [AW-1:0] first, input int n_exp);
        logic [AW-1:0] exp_pc;
        int            got;
        exp_pc = first;
        got = 0;
        halt = 1'b1;
        instr_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (c > 0 && !busy) break;
            if (c == 1) halt = 1'b0;
            if (c > 0) check("halt_no_cs", 32'(bus.mem_chipselect), 32'd0);
            if (bus.instr_valid) begin
                $display("drain pc=%h data=%h", bus.instr_pc, bus.instr_data);
                check("drain_pc", 32'(bus.instr_pc), 32'(exp_pc));
                check("drain_data", bus.instr_data, word(exp_pc));
                exp_pc = exp_pc + AW'(1);
                got++;
            end
            tick();
        end
        halt = 1'b0;
        check("drain_count", 32'(got), 32'(n_exp));
        check("drain_busy", 32'(busy), 32'd0);
        check("drain_valid", 32'(bus.instr_valid), 32'd0);
        repeat (3) tick();
        check("idle_cs", 32'(bus.mem_chipselect), 32'd0);
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_addr", 32'(bus.mem_address), 32'd0);
        check("rst_cs", 32'(bus.mem_chipselect), 32'd0);
        check("rst_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_data", bus.instr_data, 32'd0);
        check("rst_pc", 32'(bus.instr_pc), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_write", 32'(bus.mem_write), 32'd0);
        check("rst_be", 32'(bus.mem_byteenable), 32'hF);
        check("rst_clken", 32'(bus.mem_clken), 32'd1);
        reset = 1'b0;
        tick();

        // Start at 0x010, ready held high: 3-cycle latency then one word per cycle
        instr_ready = 1'b1;
        pulse_start(13'h010);
        check("start_cs", 32'(bus.mem_chipselect), 32'd1);
        check("start_addr", 32'(bus.mem_address), 32'h010);
        check("lat_e0_valid", 32'(bus.instr_valid), 32'd0);
        tick();
        check("lat_e1_valid", 32'(bus.instr_valid), 32'd0);
        tick();
        for (int i = 0; i < 6; i++) begin
            $display("pop pc=%h data=%h", bus.instr_pc, bus.instr_data);
            check("tput_valid", 32'(bus.instr_valid), 32'd1);
            check("tput_pc", 32'(bus.instr_pc), 32'(13'h010 + 13'(i)));
            check("tput_data", bus.instr_data, 32'hA000_0010 + 32'(i));
            tick();
        end
        // Halt: head 0x016, pending 0x017, and 0x018 issued on the halt edge
        drain(13'h016, 3);

        // Backpressure: exactly four words buffered, then contiguous delivery
        instr_ready = 1'b0;
        pulse_start(13'h010);
        repeat (10) tick();
        check("bp_cs", 32'(bus.mem_chipselect), 32'd0);
        check("bp_valid", 32'(bus.instr_valid), 32'd1);
        check("bp_pc", 32'(bus.instr_pc), 32'h010);
        check("bp_busy", 32'(busy), 32'd1);
        instr_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            $display("pop pc=%h data=%h", bus.instr_pc, bus.instr_data);
            check("bp_stream_valid", 32'(bus.instr_valid), 32'd1);
            check("bp_stream_pc", 32'(bus.instr_pc), 32'(13'h010 + 13'(i)));
            check("bp_stream_data", bus.instr_data, 32'hA000_0010 + 32'(i));
            tick();
        end

        // Address wrap at the top of memory
        pulse_start(13'h1FFE);
        collect(4, 13'h1FFE, 12);

        // Redirect with three words buffered and one read in flight
        instr_ready = 1'b0;
        pulse_start(13'h020);
        repeat (4) tick();
        check("pre_redir_valid", 32'(bus.instr_valid), 32'd1);
        check("pre_redir_pc", 32'(bus.instr_pc), 32'h020);
        check("pre_redir_cs", 32'(bus.mem_chipselect), 32'd0);
        redirect    = 1'b1;
        redirect_pc = 13'h100;
        tick();
        redirect = 1'b0;
        check("redir_flush_valid", 32'(bus.instr_valid), 32'd0);
        check("redir_addr", 32'(bus.mem_address), 32'h100);
        collect(4, 13'h100, 12);

        // Halt and start together: start wins
        halt     = 1'b1;
        start    = 1'b1;
        start_pc = 13'h040;
        tick();
        halt  = 1'b0;
        start = 1'b0;
        check("hs_cs", 32'(bus.mem_chipselect), 32'd1);
        check("hs_addr", 32'(bus.mem_address), 32'h040);
        collect(2, 13'h040, 10);
        drain(13'h042, 3);

        // Synchronous reset with the FIFO non-empty
        instr_ready = 1'b0;
        pulse_start(13'h050);
        repeat (4) tick();
        check("pre_rst_valid", 32'(bus.instr_valid), 32'd1);
        reset = 1'b1;
        tick();
        check("mid_rst_valid", 32'(bus.instr_valid), 32'd0);
        check("mid_rst_addr", 32'(bus.mem_address), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_cs", 32'(bus.mem_chipselect), 32'd0);
        check("mid_rst_data", bus.instr_data, 32'd0);
        check("mid_rst_pc", 32'(bus.instr_pc), 32'd0);
        reset = 1'b0;
        repeat (2) tick();
        check("post_rst_cs", 32'(bus.mem_chipselect), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
